// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types used by the data-memory / writeback stage.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [2:0]  lc3b_reg;
    typedef logic [1:0]  lc3b_2bit;

    typedef enum logic [3:0] {
        op_br   = 4'b0000,
        op_add  = 4'b0001,
        op_ldb  = 4'b0010,
        op_stb  = 4'b0011,
        op_jsr  = 4'b0100,
        op_and  = 4'b0101,
        op_ldr  = 4'b0110,
        op_str  = 4'b0111,
        op_rti  = 4'b1000,
        op_not  = 4'b1001,
        op_ldi  = 4'b1010,
        op_sti  = 4'b1011,
        op_jmp  = 4'b1100,
        op_shf  = 4'b1101,
        op_lea  = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode;

    typedef struct packed {
        lc3b_opcode opcode;
        logic       load_regfile;
        logic       load_cc;
        lc3b_2bit   wb_sel;
    } lc3b_control_word;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } dmem_state_t;

    localparam lc3b_2bit WMASK_ALL = 2'b11;

    // Byte load: odd address selects the high lane, zero-extended.
    function automatic lc3b_word ldb_extract(input lc3b_word rdata,
                                             input logic     odd);
        return odd ? {8'h00, rdata[15:8]} : {8'h00, rdata[7:0]};
    endfunction

endpackage

// File: rtl/dmem_perf_counter.sv
// Saturating event counter, cleared by asynchronous active-low reset.
module dmem_perf_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/dmem_wb_stage.sv
// Data-memory handshake and MEM/WB pipeline register for the LC-3b core.
// Optional perf counters enabled with `define DMEM_PERF_CNT_EN.
module dmem_wb_stage
    import lc3b_types::*;
#(
    parameter int PERF_WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             mem_read_b,
    input  logic             mem_write_b,
    input  lc3b_word         mem_address_b,
    input  lc3b_word         mem_wdata_b,
    input  lc3b_2bit         mem_wmask_b,
    input  lc3b_control_word ctrl_in,
    input  lc3b_reg          dest_in,
    input  lc3b_word         alu_in,
    input  lc3b_word         mem_pc_in,
    output logic             dmem_read,
    output logic             dmem_write,
    output lc3b_word         dmem_address,
    output lc3b_word         dmem_wdata,
    output lc3b_2bit         dmem_wmask,
    input  logic             dmem_resp,
    input  lc3b_word         dmem_rdata,
    output logic             stall,
    output logic             wb_valid,
    output lc3b_control_word wb_ctrl,
    output lc3b_reg          wb_dest,
    output lc3b_word         wb_alu,
    output lc3b_word         wb_mdr,
    output lc3b_word         wb_pc
`ifdef DMEM_PERF_CNT_EN
    ,
    output logic [PERF_WIDTH-1:0] perf_accesses,
    output logic [PERF_WIDTH-1:0] perf_stall_cycles
`endif
);

    dmem_state_t      r_state;
    dmem_state_t      w_next_state;
    logic             w_req;
    logic             w_stall;
    logic             w_start;

    logic             r_dmem_read;
    logic             r_dmem_write;
    lc3b_word         r_dmem_address;
    lc3b_word         r_dmem_wdata;
    lc3b_2bit         r_dmem_wmask;

    lc3b_control_word r_hold_ctrl;
    lc3b_reg          r_hold_dest;
    lc3b_word         r_hold_alu;
    lc3b_word         r_hold_pc;

    logic             r_wb_valid;
    lc3b_control_word r_wb_ctrl;
    lc3b_reg          r_wb_dest;
    lc3b_word         r_wb_alu;
    lc3b_word         r_wb_mdr;
    lc3b_word         r_wb_pc;
    lc3b_word         w_load_data;

    // Read and write together is illegal and degrades to a plain pass-through.
    assign w_req = mem_read_b ^ mem_write_b;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_stall      = 1'b0;
        w_start      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_next_state = ACCESS;
                    w_stall      = 1'b1;
                    w_start      = 1'b1;
                end
            end
            ACCESS: begin
                if (dmem_resp) begin
                    w_next_state = IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        w_load_data = '0;
        if (r_dmem_read) begin
            if (r_hold_ctrl.opcode == op_ldb) begin
                w_load_data = ldb_extract(dmem_rdata, r_dmem_address[0]);
            end else begin
                w_load_data = dmem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dmem_read    <= 1'b0;
            r_dmem_write   <= 1'b0;
            r_dmem_address <= '0;
            r_dmem_wdata   <= '0;
            r_dmem_wmask   <= WMASK_ALL;
            r_hold_ctrl    <= '0;
            r_hold_dest    <= '0;
            r_hold_alu     <= '0;
            r_hold_pc      <= '0;
            r_wb_valid     <= 1'b0;
            r_wb_ctrl      <= '0;
            r_wb_dest      <= '0;
            r_wb_alu       <= '0;
            r_wb_mdr       <= '0;
            r_wb_pc        <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_dmem_read    <= mem_read_b;
                        r_dmem_write   <= mem_write_b;
                        r_dmem_address <= mem_address_b;
                        r_dmem_wdata   <= mem_wdata_b;
                        r_dmem_wmask   <= mem_wmask_b;
                        r_hold_ctrl    <= ctrl_in;
                        r_hold_dest    <= dest_in;
                        r_hold_alu     <= alu_in;
                        r_hold_pc      <= mem_pc_in;
                        r_wb_valid     <= 1'b0;
                    end else begin
                        r_wb_valid <= 1'b1;
                        r_wb_ctrl  <= ctrl_in;
                        r_wb_dest  <= dest_in;
                        r_wb_alu   <= alu_in;
                        r_wb_mdr   <= '0;
                        r_wb_pc    <= mem_pc_in;
                    end
                end
                ACCESS: begin
                    if (dmem_resp) begin
                        r_dmem_read  <= 1'b0;
                        r_dmem_write <= 1'b0;
                        r_wb_valid   <= 1'b1;
                        r_wb_ctrl    <= r_hold_ctrl;
                        r_wb_dest    <= r_hold_dest;
                        r_wb_alu     <= r_hold_alu;
                        r_wb_mdr     <= w_load_data;
                        r_wb_pc      <= r_hold_pc;
                    end else begin
                        r_wb_valid <= 1'b0;
                    end
                end
                default: begin
                    r_wb_valid <= 1'b0;
                end
            endcase
        end
    end

    assign dmem_read    = r_dmem_read;
    assign dmem_write   = r_dmem_write;
    assign dmem_address = r_dmem_address;
    assign dmem_wdata   = r_dmem_wdata;
    assign dmem_wmask   = r_dmem_wmask;
    assign stall        = w_stall;
    assign wb_valid     = r_wb_valid;
    assign wb_ctrl      = r_wb_ctrl;
    assign wb_dest      = r_wb_dest;
    assign wb_alu       = r_wb_alu;
    assign wb_mdr       = r_wb_mdr;
    assign wb_pc        = r_wb_pc;

    if (PERF_WIDTH < 1) begin : g_perf_width_check
        $error("PERF_WIDTH must be at least 1");
    end

`ifdef DMEM_PERF_CNT_EN
    dmem_perf_counter #(
        .WIDTH(PERF_WIDTH)
    ) u_perf_accesses (
        .clk    (clk),
        .reset_n(reset_n),
        .inc    (w_start),
        .count  (perf_accesses)
    );

    dmem_perf_counter #(
        .WIDTH(PERF_WIDTH)
    ) u_perf_stalls (
        .clk    (clk),
        .reset_n(reset_n),
        .inc    (w_stall),
        .count  (perf_stall_cycles)
    );
`else
    logic w_start_unused;
    assign w_start_unused = w_start;
`endif

endmodule

// File: tb/tb_dmem_wb_stage.sv
// Directed bench for dmem_wb_stage: handshake, stall, LDB extraction, reset abort.
module tb_dmem_wb_stage;
    import lc3b_types::*;

    logic             clk;
    logic             reset_n;
    logic             mem_read_b;
    logic             mem_write_b;
    lc3b_word         mem_address_b;
    lc3b_word         mem_wdata_b;
    lc3b_2bit         mem_wmask_b;
    lc3b_control_word ctrl_in;
    lc3b_reg          dest_in;
    lc3b_word         alu_in;
    lc3b_word         mem_pc_in;
    logic             dmem_read;
    logic             dmem_write;
    lc3b_word         dmem_address;
    lc3b_word         dmem_wdata;
    lc3b_2bit         dmem_wmask;
    logic             dmem_resp;
    lc3b_word         dmem_rdata;
    logic             stall;
    logic             wb_valid;
    lc3b_control_word wb_ctrl;
    lc3b_reg          wb_dest;
    lc3b_word         wb_alu;
    lc3b_word         wb_mdr;
    lc3b_word         wb_pc;
`ifdef DMEM_PERF_CNT_EN
    logic [31:0]      perf_accesses;
    logic [31:0]      perf_stall_cycles;
`endif

    int errors = 0;
    int checks = 0;
    int stall_cnt = 0;
    int stall_since_rst = 0;
    int s0;

    dmem_wb_stage #(
        .PERF_WIDTH(32)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .mem_read_b   (mem_read_b),
        .mem_write_b  (mem_write_b),
        .mem_address_b(mem_address_b),
        .mem_wdata_b  (mem_wdata_b),
        .mem_wmask_b  (mem_wmask_b),
        .ctrl_in      (ctrl_in),
        .dest_in      (dest_in),
        .alu_in       (alu_in),
        .mem_pc_in    (mem_pc_in),
        .dmem_read    (dmem_read),
        .dmem_write   (dmem_write),
        .dmem_address (dmem_address),
        .dmem_wdata   (dmem_wdata),
        .dmem_wmask   (dmem_wmask),
        .dmem_resp    (dmem_resp),
        .dmem_rdata   (dmem_rdata),
        .stall        (stall),
        .wb_valid     (wb_valid),
        .wb_ctrl      (wb_ctrl),
        .wb_dest      (wb_dest),
        .wb_alu       (wb_alu),
        .wb_mdr       (wb_mdr),
        .wb_pc        (wb_pc)
`ifdef DMEM_PERF_CNT_EN
        ,
        .perf_accesses    (perf_accesses),
        .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset_n) begin
            stall_since_rst = 0;
        end else if (stall) begin
            stall_cnt++;
            stall_since_rst++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        mem_read_b    = 1'b0;
        mem_write_b   = 1'b0;
        mem_address_b = '0;
        mem_wdata_b   = '0;
        mem_wmask_b   = 2'b11;
        ctrl_in       = '0;
        dest_in       = '0;
        alu_in        = '0;
        mem_pc_in     = '0;
        dmem_resp     = 1'b0;
        dmem_rdata    = '0;
        #12;
        chk("rst_dmem_read", 32'(dmem_read), 32'd0);
        chk("rst_dmem_write", 32'(dmem_write), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wmask", 32'(dmem_wmask), 32'h3);
        chk("rst_address", 32'(dmem_address), 32'h0);
        chk("rst_wb_alu", 32'(wb_alu), 32'h0);
        tick();
        reset_n = 1'b1;

        // Non-memory ADD passes straight through.
        ctrl_in.opcode = op_add;
        dest_in   = 3'd3;
        alu_in    = 16'h1234;
        mem_pc_in = 16'h0100;
        #1;
        chk("add_stall", 32'(stall), 32'd0);
        tick();
        chk("add_wb_valid", 32'(wb_valid), 32'd1);
        chk("add_wb_alu", 32'(wb_alu), 32'h1234);
        chk("add_wb_dest", 32'(wb_dest), 32'd3);
        chk("add_wb_mdr", 32'(wb_mdr), 32'h0);
        chk("add_wb_pc", 32'(wb_pc), 32'h0100);
        chk("add_stall_after", 32'(stall), 32'd0);

        // LDW at x3000, response 3 cycles after the strobe.
        ctrl_in.opcode = op_ldr;
        mem_read_b     = 1'b1;
        mem_address_b  = 16'h3000;
        dest_in        = 3'd1;
        alu_in         = 16'h3000;
        mem_pc_in      = 16'h0102;
        s0             = stall_cnt;
        #1;
        chk("ldw_stall_req", 32'(stall), 32'd1);
        tick();
        chk("ldw_strobe", 32'(dmem_read), 32'd1);
        chk("ldw_addr", 32'(dmem_address), 32'h3000);
        chk("ldw_bubble", 32'(wb_valid), 32'd0);
        tick();
        tick();
        tick();
        chk("ldw_wait_stall", 32'(stall), 32'd1);
        dmem_resp  = 1'b1;
        dmem_rdata = 16'hBEEF;
        #1;
        chk("ldw_resp_stall", 32'(stall), 32'd0);
        tick();
        dmem_resp      = 1'b0;
        mem_read_b     = 1'b0;
        ctrl_in.opcode = op_add;
        dest_in        = 3'd2;
        alu_in         = 16'h5555;
        mem_pc_in      = 16'h0104;
        chk("ldw_wb_valid", 32'(wb_valid), 32'd1);
        chk("ldw_wb_mdr", 32'(wb_mdr), 32'hBEEF);
        chk("ldw_wb_alu", 32'(wb_alu), 32'h3000);
        chk("ldw_wb_dest", 32'(wb_dest), 32'd1);
        chk("ldw_wb_pc", 32'(wb_pc), 32'h0102);
        chk("ldw_strobe_drop", 32'(dmem_read), 32'd0);
        chk("ldw_stall_cycles", 32'(stall_cnt - s0), 32'd4);
        tick();
        chk("post_ldw_alu", 32'(wb_alu), 32'h5555);
        chk("post_ldw_mdr", 32'(wb_mdr), 32'h0);

        // LDB high lane then low lane.
        ctrl_in.opcode = op_ldb;
        mem_read_b     = 1'b1;
        mem_address_b  = 16'h3001;
        dest_in        = 3'd4;
        tick();
        dmem_resp  = 1'b1;
        dmem_rdata = 16'hA55A;
        tick();
        dmem_resp  = 1'b0;
        mem_read_b = 1'b0;
        chk("ldb_odd_mdr", 32'(wb_mdr), 32'h00A5);
        mem_read_b    = 1'b1;
        mem_address_b = 16'h3000;
        tick();
        dmem_resp = 1'b1;
        tick();
        dmem_resp  = 1'b0;
        mem_read_b = 1'b0;
        chk("ldb_even_mdr", 32'(wb_mdr), 32'h005A);
        chk("ldb_wb_ctrl", 32'(wb_ctrl), 32'(op_ldb) << 4);

        // STB held stable until the response.
        ctrl_in.opcode = op_stb;
        mem_write_b    = 1'b1;
        mem_address_b  = 16'h4001;
        mem_wdata_b    = 16'h7700;
        mem_wmask_b    = 2'b10;
        alu_in         = 16'h4001;
        #1;
        chk("stb_stall_req", 32'(stall), 32'd1);
        tick();
        chk("stb_write", 32'(dmem_write), 32'd1);
        chk("stb_read", 32'(dmem_read), 32'd0);
        chk("stb_addr", 32'(dmem_address), 32'h4001);
        chk("stb_wdata", 32'(dmem_wdata), 32'h7700);
        chk("stb_wmask", 32'(dmem_wmask), 32'h2);
        mem_address_b = 16'hFFFF;
        mem_wdata_b   = 16'h0000;
        mem_wmask_b   = 2'b11;
        tick();
        chk("stb_hold_addr", 32'(dmem_address), 32'h4001);
        chk("stb_hold_wdata", 32'(dmem_wdata), 32'h7700);
        chk("stb_hold_wmask", 32'(dmem_wmask), 32'h2);
        chk("stb_hold_write", 32'(dmem_write), 32'd1);
        dmem_resp  = 1'b1;
        dmem_rdata = 16'h9999;
        tick();
        dmem_resp   = 1'b0;
        mem_write_b = 1'b0;
        chk("stb_write_drop", 32'(dmem_write), 32'd0);
        chk("stb_wb_mdr", 32'(wb_mdr), 32'h0);
        chk("stb_wb_valid", 32'(wb_valid), 32'd1);
        chk("stb_wb_alu", 32'(wb_alu), 32'h4001);

        // Reset during ACCESS, then a stray response.
        ctrl_in.opcode = op_ldr;
        mem_read_b     = 1'b1;
        mem_address_b  = 16'h5000;
        alu_in         = 16'h5000;
        tick();
        chk("abort_strobe", 32'(dmem_read), 32'd1);
        reset_n    = 1'b0;
        mem_read_b = 1'b0;
        #1;
        chk("abort_read", 32'(dmem_read), 32'd0);
        chk("abort_wb_valid", 32'(wb_valid), 32'd0);
        chk("abort_addr", 32'(dmem_address), 32'h0);
        tick();
        reset_n    = 1'b1;
        dmem_resp  = 1'b1;
        dmem_rdata = 16'h1111;
        tick();
        dmem_resp = 1'b0;
        chk("stray_read", 32'(dmem_read), 32'd0);
        chk("stray_mdr", 32'(wb_mdr), 32'h0);
        chk("stray_stall", 32'(stall), 32'd0);

        // Back-to-back LDW then STW, zero-wait memory.
        ctrl_in.opcode = op_ldr;
        mem_read_b     = 1'b1;
        mem_address_b  = 16'h6000;
        alu_in         = 16'h6000;
        s0             = stall_cnt;
        tick();
        dmem_resp  = 1'b1;
        dmem_rdata = 16'h1357;
        tick();
        dmem_resp      = 1'b0;
        mem_read_b     = 1'b0;
        mem_write_b    = 1'b1;
        ctrl_in.opcode = op_str;
        mem_address_b  = 16'h6002;
        mem_wdata_b    = 16'h2468;
        mem_wmask_b    = 2'b11;
        alu_in         = 16'h6002;
        #1;
        chk("b2b_stall", 32'(stall), 32'd1);
        chk("b2b_ld_mdr", 32'(wb_mdr), 32'h1357);
        chk("b2b_ld_valid", 32'(wb_valid), 32'd1);
        tick();
        chk("b2b_st_write", 32'(dmem_write), 32'd1);
        chk("b2b_st_addr", 32'(dmem_address), 32'h6002);
        dmem_resp = 1'b1;
        tick();
        dmem_resp   = 1'b0;
        mem_write_b = 1'b0;
        chk("b2b_st_valid", 32'(wb_valid), 32'd1);
        chk("b2b_st_mdr", 32'(wb_mdr), 32'h0);
        chk("b2b_stall_cycles", 32'(stall_cnt - s0), 32'd2);
`ifdef DMEM_PERF_CNT_EN
        chk("perf_accesses", perf_accesses, 32'd2);
        chk("perf_stalls", perf_stall_cycles, 32'(stall_since_rst));
`endif

        // Read and write together: no request, plain pass-through.
        mem_read_b     = 1'b1;
        mem_write_b    = 1'b1;
        ctrl_in.opcode = op_add;
        alu_in         = 16'h7777;
        #1;
        chk("illegal_stall", 32'(stall), 32'd0);
        tick();
        chk("illegal_wb_valid", 32'(wb_valid), 32'd1);
        chk("illegal_wb_alu", 32'(wb_alu), 32'h7777);
        chk("illegal_read", 32'(dmem_read), 32'd0);
        chk("illegal_write", 32'(dmem_write), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
